// File: rtl/axi_mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_tester
// Purpose  : AXI4 master built-in self-test for the SoC memory path. The test
//            writes the pattern (addr ^ SEED) over a region in INCR bursts. It
//            then reads the region back and checks every beat. It reports
//            pass/fail, a saturating error count and the first failing
//            address.
// Ports    : clk, reset (async, active high), start
//            busy, done, pass, err_count[15:0], first_err_addr[31:0]
//            mem_axi_* : AXI4 master, AW/W/B/AR/R channels, one transaction
//                        outstanding at a time
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_tester #(
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter int unsigned NUM_BURSTS = 16,
   parameter int unsigned BURST_LEN  = 8,
   parameter logic [5:0]  AXI_ID     = 6'h00,
   parameter logic [31:0] SEED       = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] first_err_addr,
   output logic [5:0]  mem_axi_awid,
   output logic [31:0] mem_axi_awaddr,
   output logic [7:0]  mem_axi_awlen,
   output logic [2:0]  mem_axi_awsize,
   output logic [1:0]  mem_axi_awburst,
   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_wlast,
   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic        mem_axi_bready,
   input  logic [5:0]  mem_axi_bid,
   input  logic [1:0]  mem_axi_bresp,
   input  logic        mem_axi_bvalid,
   output logic [5:0]  mem_axi_arid,
   output logic [31:0] mem_axi_araddr,
   output logic [7:0]  mem_axi_arlen,
   output logic [2:0]  mem_axi_arsize,
   output logic [1:0]  mem_axi_arburst,
   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic        mem_axi_rready,
   input  logic [5:0]  mem_axi_rid,
   input  logic [31:0] mem_axi_rdata,
   input  logic [1:0]  mem_axi_rresp,
   input  logic        mem_axi_rlast,
   input  logic        mem_axi_rvalid
);

   localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
   localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
   localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] k_q, k_d;          // burst index within the current phase
   logic [7:0]  beat_q, beat_d;    // beat index within the current burst
   logic [31:0] addr_q, addr_d;    // start address of the current burst
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] err_q, err_d;
   logic [31:0] first_q, first_d;

   logic [31:0] beat_addr;
   logic [31:0] pattern;
   logic        err_hit;
   logic [31:0] err_addr;
   logic        last_beat;

   assign beat_addr = addr_q + {22'd0, beat_q, 2'b00};
   assign pattern   = beat_addr ^ SEED;
   assign last_beat = (beat_q == LAST_BEAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= 16'd0;
         beat_q  <= 8'd0;
         addr_q  <= ADDR_BASE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 16'd0;
         first_q <= 32'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      beat_d   = beat_q;
      addr_d   = addr_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      first_d  = first_q;
      err_hit  = 1'b0;
      err_addr = addr_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_WR_ADDR;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 16'd0;
               first_d = 32'd0;
               k_d     = 16'd0;
               addr_d  = ADDR_BASE;
            end
         end
         S_WR_ADDR: begin
            if (mem_axi_awready) begin
               state_d = S_WR_DATA;
               beat_d  = 8'd0;
            end
         end
         S_WR_DATA: begin
            if (mem_axi_wready) begin
               if (last_beat) state_d = S_WR_RESP;
               else           beat_d  = beat_q + 8'd1;
            end
         end
         S_WR_RESP: begin
            if (mem_axi_bvalid) begin
               err_hit  = (mem_axi_bresp != 2'b00) || (mem_axi_bid != AXI_ID);
               err_addr = addr_q;
               if (k_q == LAST_BURST) begin
                  state_d = S_RD_ADDR;
                  k_d     = 16'd0;
                  addr_d  = ADDR_BASE;
               end else begin
                  state_d = S_WR_ADDR;
                  k_d     = k_q + 16'd1;
                  addr_d  = addr_q + BURST_BYTES;
               end
            end
         end
         S_RD_ADDR: begin
            if (mem_axi_arready) begin
               state_d = S_RD_DATA;
               beat_d  = 8'd0;
            end
         end
         S_RD_DATA: begin
            if (mem_axi_rvalid) begin
               err_hit  = (mem_axi_rdata != pattern) || (mem_axi_rresp != 2'b00) ||
                          (mem_axi_rid != AXI_ID) || (mem_axi_rlast != last_beat);
               err_addr = beat_addr;
               // Exit is driven by our own beat count, not by rlast, so a
               // misplaced rlast cannot stall or shorten the burst.
               if (last_beat) begin
                  if (k_q == LAST_BURST) begin
                     state_d = S_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_RD_ADDR;
                     k_d     = k_q + 16'd1;
                     addr_d  = addr_q + BURST_BYTES;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (err_hit) begin
         if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
         if (err_q == 16'd0)    first_d = err_addr;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = done_q && (err_q == 16'd0);
   assign err_count      = err_q;
   assign first_err_addr = first_q;

   assign mem_axi_awid    = AXI_ID;
   assign mem_axi_awaddr  = addr_q;
   assign mem_axi_awlen   = LAST_BEAT;
   assign mem_axi_awsize  = 3'b010;
   assign mem_axi_awburst = 2'b01;
   assign mem_axi_awvalid = (state_q == S_WR_ADDR);
   assign mem_axi_wdata   = pattern;
   assign mem_axi_wstrb   = 4'hF;
   assign mem_axi_wlast   = last_beat;
   assign mem_axi_wvalid  = (state_q == S_WR_DATA);
   assign mem_axi_bready  = (state_q == S_WR_RESP);
   assign mem_axi_arid    = AXI_ID;
   assign mem_axi_araddr  = addr_q;
   assign mem_axi_arlen   = LAST_BEAT;
   assign mem_axi_arsize  = 3'b010;
   assign mem_axi_arburst = 2'b01;
   assign mem_axi_arvalid = (state_q == S_RD_ADDR);
   assign mem_axi_rready  = (state_q == S_RD_DATA);

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_tester
// Purpose  : Self-checking bench for axi_mem_tester. A behavioural AXI slave
//            with a word memory answers the DUT. Each handshake is compared
//            against the expected address/pattern sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_tester;

   localparam logic [31:0] SEED = 32'h0000_0001;

   logic        clk = 1'b0;
   logic        reset, start;
   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [31:0] first_err_addr;
   logic [5:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
   logic        arvalid, arready, rready, rvalid, rlast;
   logic [3:0]  wstrb;

   axi_mem_tester dut (
      .clk(clk), .reset(reset), .start(start),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_addr(first_err_addr),
      .mem_axi_awid(awid), .mem_axi_awaddr(awaddr), .mem_axi_awlen(awlen),
      .mem_axi_awsize(awsize), .mem_axi_awburst(awburst),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
      .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_wlast(wlast),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
      .mem_axi_bready(bready), .mem_axi_bid(bid), .mem_axi_bresp(bresp),
      .mem_axi_bvalid(bvalid),
      .mem_axi_arid(arid), .mem_axi_araddr(araddr), .mem_axi_arlen(arlen),
      .mem_axi_arsize(arsize), .mem_axi_arburst(arburst),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
      .mem_axi_rready(rready), .mem_axi_rid(rid), .mem_axi_rdata(rdata),
      .mem_axi_rresp(rresp), .mem_axi_rlast(rlast), .mem_axi_rvalid(rvalid)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Slave / reference model state
   logic [31:0] mem [int unsigned];
   int          wr_k, wbeat, rd_k, rbeat;
   bit          aw_done, b_pending, r_active;
   bit          aw_hold, w_hold, ar_hold, r_hold;
   logic [31:0] aw_hold_addr, w_hold_data, ar_hold_addr;
   logic        w_hold_last;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic [31:0] first_wdata, wdata_1fc;

   // Fault knobs
   bit          bp_en;
   int          bresp_burst;     // -1: none
   bit          flip_en;
   logic [31:0] flip_addr;
   bit          early_rlast;

   task automatic slave_clear();
      wr_k = 0; wbeat = 0; rd_k = 0; rbeat = 0;
      aw_done = 0; b_pending = 0; r_active = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0; r_hold = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
   endtask

   // Slave: drive on negedge, evaluate handshakes 1ns before posedge.
   initial begin
      logic [31:0] a;
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bresp = 0; bid = 0;
      rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
      slave_clear();
      forever begin
         @(negedge clk);
         if (reset) begin
            slave_clear();
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         end else begin
            awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            arready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_pending) begin
               if (!bvalid) begin
                  bvalid = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
                  bresp  = (bresp_burst == wr_k - 1) ? 2'b10 : 2'b00;
                  bid    = 6'h00;
               end
            end else begin
               bvalid = 0;
            end
            if (r_active) begin
               if (!r_hold) begin
                  rvalid = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
                  a      = 32'(rd_k * 32 + rbeat * 4);
                  rdata  = mem[a] ^ ((flip_en && a == flip_addr) ? 32'h1 : 32'h0);
                  rresp  = 2'b00;
                  rid    = 6'h00;
                  rlast  = (early_rlast && rd_k == 0) ? (rbeat == 6) : (rbeat == 7);
               end
            end else begin
               rvalid = 0;
            end
         end

         #4;
         if (!reset) begin
            if (aw_hold) begin
               chk("awvalid_held", 32'(awvalid), 32'd1);
               chk("awaddr_stable", awaddr, aw_hold_addr);
            end
            if (w_hold) begin
               chk("wvalid_held", 32'(wvalid), 32'd1);
               chk("wdata_stable", wdata, w_hold_data);
               chk("wlast_stable", 32'(wlast), 32'(w_hold_last));
            end
            if (ar_hold) begin
               chk("arvalid_held", 32'(arvalid), 32'd1);
               chk("araddr_stable", araddr, ar_hold_addr);
            end
            if (wvalid) chk("wvalid_after_aw", 32'(aw_done), 32'd1);

            if (awvalid && awready) begin
               chk("awaddr", awaddr, 32'(wr_k * 32));
               chk("aw_fields", {awid, awlen, awsize, awburst}, {6'h00, 8'd7, 3'b010, 2'b01});
               aw_done = 1; wbeat = 0; aw_cnt++;
            end
            if (wvalid && wready) begin
               a = 32'(wr_k * 32 + wbeat * 4);
               chk("wdata", wdata, a ^ SEED);
               chk("wlast", 32'(wlast), 32'(wbeat == 7));
               chk("wstrb", 32'(wstrb), 32'hF);
               if (a == 32'h0)   first_wdata = wdata;
               if (a == 32'h1FC) wdata_1fc   = wdata;
               mem[a] = wdata;
               w_cnt++;
               if (wbeat == 7) begin
                  aw_done = 0; b_pending = 1; wr_k++;
               end
               wbeat++;
            end
            if (bvalid && bready) begin
               b_pending = 0; b_cnt++;
            end
            if (arvalid && arready) begin
               chk("araddr", araddr, 32'(rd_k * 32));
               chk("ar_fields", {arid, arlen, arsize, arburst}, {6'h00, 8'd7, 3'b010, 2'b01});
               r_active = 1; rbeat = 0; ar_cnt++;
            end
            r_hold = rvalid && !rready;
            if (rvalid && rready) begin
               r_cnt++; rbeat++;
               if (rbeat == 8) begin
                  r_active = 0; rd_k++;
               end
            end
            aw_hold = awvalid && !awready; aw_hold_addr = awaddr;
            w_hold  = wvalid && !wready;   w_hold_data = wdata; w_hold_last = wlast;
            ar_hold = arvalid && !arready; ar_hold_addr = araddr;
         end
      end
   end

   task automatic run_test(input string name, input logic [15:0] exp_err,
                           input logic [31:0] exp_first, input logic exp_pass);
      int n;
      @(negedge clk);
      slave_clear();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      n = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_pass"}, 32'(pass), 32'(exp_pass));
      chk({name, "_err_count"}, 32'(err_count), 32'(exp_err));
      chk({name, "_first_err_addr"}, first_err_addr, exp_first);
      chk({name, "_aw_cnt"}, 32'(aw_cnt), 32'd16);
      chk({name, "_w_cnt"},  32'(w_cnt),  32'd128);
      chk({name, "_b_cnt"},  32'(b_cnt),  32'd16);
      chk({name, "_ar_cnt"}, 32'(ar_cnt), 32'd16);
      chk({name, "_r_cnt"},  32'(r_cnt),  32'd128);
   endtask

   initial begin
      int n;
      reset = 1; start = 0;
      bp_en = 0; bresp_burst = -1; flip_en = 0; flip_addr = 0; early_rlast = 0;
      first_wdata = 32'hDEAD_BEEF; wdata_1fc = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_first_err_addr", first_err_addr, 32'd0);
      chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 32'd0);
      reset = 0;

      // Clean run, slave always ready
      run_test("clean", 16'd0, 32'd0, 1'b1);
      chk("first_wdata", first_wdata, 32'h0000_0001);
      chk("wdata_at_1fc", wdata_1fc, 32'h0000_01FD);

      // Corrupted read beat at 0x74 (burst 3, beat 5)
      flip_en = 1; flip_addr = 32'h74;
      run_test("rdata_flip", 16'd1, 32'h74, 1'b0);
      flip_en = 0;

      // Random backpressure and response gaps
      bp_en = 1;
      run_test("backpressure", 16'd0, 32'd0, 1'b1);
      bp_en = 0;

      // SLVERR on write burst 0
      bresp_burst = 0;
      run_test("bresp_err", 16'd1, 32'd0, 1'b0);
      bresp_burst = -1;

      // rlast one beat early in read burst 0
      early_rlast = 1;
      run_test("early_rlast", 16'd2, 32'h18, 1'b0);
      early_rlast = 0;

      // Reset mid-burst during W beats of burst 2
      @(negedge clk); slave_clear();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      n = 0;
      while (w_cnt < 19 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_wvalid", 32'(wvalid), 32'd1);
      #2 reset = 1;
      #1;
      chk("async_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_err_count", 32'(err_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 0;
      run_test("after_reset", 16'd0, 32'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_mem_tester.md
Name: axi_mem_tester

Overview:
- AXI4 initiator (master) built-in self-test for the SoC memory path; it is the master end of the mem_axi interface.
- Connects where soc_top normally drives the SDRAM controller's AXI slave port, selected by a test mux.
- Writes a deterministic pattern over a region in INCR bursts, reads it back, compares every beat, and reports the pass/fail status and error details.

Parameters:
- ADDR_BASE, 32'h0000_0000: byte address of the region start. Must be aligned to BURST_LEN*4.
- NUM_BURSTS, 16: number of bursts per phase. Legal range is 1..65535.
- BURST_LEN, 8: beats per burst. Legal range is 1..256, and BURST_LEN*4 <= 4096.
- AXI_ID, 6'h00: ID driven on awid and arid.
- SEED, 32'h0000_0001: pattern seed.

Ports:
- clk  in  1  single clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a test (level sampled on the clock edge).
- busy  out  1  high while a test runs.
- done  out  1  high once the test has finished; held until the next start.
- pass  out  1  equals done && (err_count==0).
- err_count  out  16  saturating error count.
- first_err_addr  out  32  byte address of the first error.
- mem_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  6/32/8/3/2/1  AXI write address channel.
- mem_axi_awready  in  1
- mem_axi_wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel.
- mem_axi_wready  in  1
- mem_axi_bready  out  1;  mem_axi_bid/bresp/bvalid  in  6/2/1  AXI write response channel.
- mem_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  6/32/8/3/2/1  AXI read address channel.
- mem_axi_arready  in  1
- mem_axi_rready  out  1;  mem_axi_rid/rdata/rresp/rlast/rvalid  in  6/32/2/1/1  AXI read data channel.

Behaviour:
- Reset values: all valid/ready outputs 0; busy=0, done=0, pass=0, err_count=0, first_err_addr=0; state IDLE. Reset acts immediately and asynchronously, including mid-burst; no transfer is resumed afterwards.
- Fixed fields: awlen=arlen=BURST_LEN-1; awsize=arsize=3'b010; awburst=arburst=2'b01 (INCR); wstrb=4'hF; awid=arid=AXI_ID.
- Burst k (0..NUM_BURSTS-1) starts at address ADDR_BASE + k*BURST_LEN*4. Address arithmetic is 32-bit and wraps modulo 2^32.
- Pattern: data for byte address A is A ^ SEED.
- Only one transaction is outstanding at a time.
- States:
  - IDLE → WR_ADDR when start=1. Entering WR_ADDR clears done, err_count and first_err_addr, sets busy=1, and sets k=0.
  - WR_ADDR: awvalid=1 until the awready handshake, then → WR_DATA with beat=0.
  - WR_DATA: wvalid=1 with wdata=pattern(addr+beat*4); wlast=1 when beat==BURST_LEN-1. On the handshake, beat increments; the last beat goes → WR_RESP.
  - WR_RESP: bready=1. On bvalid: an error is recorded if bresp!=0 or bid!=AXI_ID (error address = burst start). Then k++; → WR_ADDR if more bursts remain, else → RD_ADDR with k=0.
  - RD_ADDR: arvalid=1 until the handshake, then → RD_DATA with beat=0.
  - RD_DATA: rready=1. Each beat is checked. The beat counts one error if any of the following hold (error address = that beat's address):
    - rdata differs from the pattern;
    - rresp!=0;
    - rid!=AXI_ID;
    - rlast != (beat==BURST_LEN-1).
  - RD_DATA exit: the FSM leaves on the counted last beat: k++ and → RD_ADDR, or → DONE after the final burst.
  - DONE: busy=0, done=1; → WR_ADDR (restart with a full clear) if start=1.
- A start while busy is ignored.
- A valid signal, once raised, stays high with stable payload until its ready handshake (AXI rule).
- wvalid is never asserted before the corresponding AW handshake.
- err_count saturates at 16'hFFFF. first_err_addr is captured only when err_count transitions from 0.
- A beat arriving in the same cycle as the state exit is the counted last beat; no extra beat is consumed.

Test Plan:
- Defaults, slave always ready, in-order responses → exactly 16 AW, 128 W, 16 B, 16 AR and 128 R handshakes. First wdata is 32'h0000_0001 at address 0; wdata at address 0x1FC is 32'h0000_01FD. Result: done=1, pass=1, err_count=0.
- Slave returns rdata ^ 1 on burst 3, beat 5 (address 0x74) → err_count=1, first_err_addr=32'h74, pass=0.
- Random backpressure on awready/wready/arready plus random rvalid/bvalid gaps → same result as the first scenario. An assertion checks valid/payload stability and that no wvalid precedes the AW handshake.
- bresp=2'b10 on write burst 0, with all else clean → err_count=1, first_err_addr=32'h0.
- rlast asserted on beat 6 instead of beat 7 in burst 0 → err_count=2 (beats 6 and 7), first_err_addr=32'h18. The FSM still completes all 16 bursts and reaches DONE.
- reset pulsed during the W beats of burst 2 → all valids drop in the same cycle (asynchronously), busy=0, err_count=0. A following start completes with pass=1.
